// File: rtl/rgen_host_arbiter.sv
// rgen_host_arbiter: round-robin arbiter of host command ports onto one register-block port, with timeout and abort
module rgen_host_arbiter #(
    parameter int REQUESTERS     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int GW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [REQUESTERS-1:0]               i_command_valid,
    input  logic [REQUESTERS-1:0]               i_write,
    input  logic [REQUESTERS-1:0]               i_read,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_write_data,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]    i_write_mask,
    output logic [REQUESTERS-1:0]               o_response_ready,
    output logic [DATA_WIDTH-1:0]               o_read_data,
    output logic [1:0]                          o_status,
    output logic                                o_command_valid,
    output logic                                o_write,
    output logic                                o_read,
    output logic [ADDRESS_WIDTH-1:0]            o_address,
    output logic [DATA_WIDTH-1:0]               o_write_data,
    output logic [DATA_WIDTH-1:0]               o_write_mask,
    input  logic                                i_response_ready,
    input  logic [DATA_WIDTH-1:0]               i_read_data,
    input  logic [1:0]                          i_status,
    output logic [GW-1:0]                       o_grant,
    output logic                                o_busy
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, next_state;
    logic [GW-1:0] grant, last_grant, pick;
    logic [7:0] count;
    logic hit, busy, abort, resp, tout;
    logic [ADDRESS_WIDTH-1:0] addr_a [REQUESTERS];
    logic [DATA_WIDTH-1:0] wdata_a [REQUESTERS];
    logic [DATA_WIDTH-1:0] wmask_a [REQUESTERS];

    // unpack per-requester command fields so the grantee can be selected by index
    always_comb begin
        for (int j = 0; j < REQUESTERS; j++) begin
            addr_a[j]  = i_address[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            wdata_a[j] = i_write_data[j*DATA_WIDTH +: DATA_WIDTH];
            wmask_a[j] = i_write_mask[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // round-robin pick: first requester above last_grant, else first from 0 upward
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int j = 0; j < REQUESTERS; j++)
            if (!hit && j > int'(last_grant) && i_command_valid[j]) begin
                hit  = 1'b1;
                pick = GW'(j);
            end
        for (int j = 0; j < REQUESTERS; j++)
            if (!hit && j <= int'(last_grant) && i_command_valid[j]) begin
                hit  = 1'b1;
                pick = GW'(j);
            end
    end

    // BUSY terminations: abort beats response, a real response beats the timeout
    always_comb begin
        busy  = state == BUSY;
        abort = busy && !i_command_valid[grant];
        resp  = busy && i_command_valid[grant] && i_response_ready;
        tout  = busy && i_command_valid[grant] && !i_response_ready && count == 8'(TIMEOUT_CYCLES - 1);
    end

    // state register plus grant bookkeeping and saturating BUSY cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            grant      <= '0;
            last_grant <= GW'(REQUESTERS - 1);
        end else begin
            state <= next_state;
            if (!busy && hit) begin
                grant <= pick;
                count <= '0;
            end else if (busy && count != 8'hff) begin
                count <= count + 8'd1;
            end
            if (abort || resp || tout)
                last_grant <= grant;
        end
    end

    // next-state: grant from IDLE on any request, leave BUSY on abort/response/timeout
    always_comb begin
        next_state = busy ? ((abort || resp || tout) ? IDLE : BUSY) : (hit ? BUSY : IDLE);
    end

    // outputs: command mux of the grantee in BUSY, response strobe and shared response bus
    always_comb begin
        o_busy           = busy;
        o_grant          = grant;
        o_command_valid  = busy && i_command_valid[grant];
        o_write          = busy && i_write[grant];
        o_read           = busy && i_read[grant];
        o_address        = busy ? addr_a[grant] : '0;
        o_write_data     = busy ? wdata_a[grant] : '0;
        o_write_mask     = busy ? wmask_a[grant] : '0;
        o_response_ready = (resp || tout) ? {{(REQUESTERS-1){1'b0}}, 1'b1} << grant : '0;
        o_read_data      = resp ? i_read_data : '0;
        o_status         = resp ? i_status : (tout ? 2'b11 : 2'b00);
    end
endmodule

// File: tb/tb_rgen_host_arbiter.sv
// tb_rgen_host_arbiter: directed self-checking bench for rgen_host_arbiter
module tb_rgen_host_arbiter;
    localparam int R = 2, DW = 32, AW = 8;
    logic clk = 1'b0, rst = 1'b1;
    logic [R-1:0] cv = '0, wr = '0, rd = '0;
    logic [R*AW-1:0] addr = '0;
    logic [R*DW-1:0] wd = '0, wm = '0;
    logic [R-1:0] rr;
    logic [DW-1:0] rdata, owd, owm;
    logic [1:0] status;
    logic ocv, ow, orrd, ob;
    logic [AW-1:0] oa;
    logic ir = 1'b0;
    logic [DW-1:0] ird = '0;
    logic [1:0] ist = '0;
    logic [0:0] og;
    int total = 0, bad = 0;

    rgen_host_arbiter #(.REQUESTERS(R), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .i_command_valid(cv), .i_write(wr), .i_read(rd), .i_address(addr),
        .i_write_data(wd), .i_write_mask(wm),
        .o_response_ready(rr), .o_read_data(rdata), .o_status(status),
        .o_command_valid(ocv), .o_write(ow), .o_read(orrd), .o_address(oa),
        .o_write_data(owd), .o_write_mask(owm),
        .i_response_ready(ir), .i_read_data(ird), .i_status(ist),
        .o_grant(og), .o_busy(ob)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        cv = '0; wr = '0; rd = '0; addr = '0; wd = '0; wm = '0;
        ir = 1'b0; ird = '0; ist = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        #1;
        total++; if (ob !== 1'b0 || ocv !== 1'b0 || rr !== 2'b00) begin bad++; $display("FAIL reset_outs got busy=%b cv=%b rr=%b exp 0 0 00", ob, ocv, rr); end
        total++; if (og !== 1'b0 || oa !== 8'h00 || owd !== 32'h0) begin bad++; $display("FAIL reset_bus got grant=%h addr=%h wd=%h exp 0", og, oa, owd); end
        tick();
        rst = 1'b0;
        ir = 1'b1; ird = 32'h5555_AAAA; ist = 2'b01;
        #1;
        total++; if (rr !== 2'b00 || rdata !== 32'h0 || status !== 2'b00) begin bad++; $display("FAIL idle_resp_ignored got rr=%b rd=%h st=%b exp 00 0 00", rr, rdata, status); end
        tick();
        clear_inputs();
        #1;
        total++; if (ob !== 1'b0) begin bad++; $display("FAIL idle_stays got busy=%b exp 0", ob); end
    endtask

    task automatic test_single;
        tick();
        cv = 2'b01; wr = 2'b01; addr[7:0] = 8'h04; wd[31:0] = 32'h1234_5678; wm[31:0] = 32'hFFFF_FFFF;
        wd[63:32] = 32'h9999_9999; addr[15:8] = 8'h77;
        #1;
        total++; if (ocv !== 1'b0 || ob !== 1'b0) begin bad++; $display("FAIL single_idle got cv=%b busy=%b exp 0 0", ocv, ob); end
        tick(); #1;
        total++; if (ocv !== 1'b1 || ow !== 1'b1 || og !== 1'b0) begin bad++; $display("FAIL single_c1 got cv=%b w=%b grant=%h exp 1 1 0", ocv, ow, og); end
        total++; if (oa !== 8'h04 || owd !== 32'h1234_5678 || owm !== 32'hFFFF_FFFF) begin bad++; $display("FAIL single_bus got a=%h d=%h m=%h exp 04 12345678 ffffffff", oa, owd, owm); end
        tick(); #1;
        total++; if (ocv !== 1'b1 || rr !== 2'b00) begin bad++; $display("FAIL single_c2 got cv=%b rr=%b exp 1 00", ocv, rr); end
        tick();
        ir = 1'b1; ist = 2'b00;
        #1;
        total++; if (ocv !== 1'b1 || rr !== 2'b01 || status !== 2'b00) begin bad++; $display("FAIL single_resp got cv=%b rr=%b st=%b exp 1 01 00", ocv, rr, status); end
        tick();
        clear_inputs();
        #1;
        total++; if (ob !== 1'b0 || ocv !== 1'b0 || rr !== 2'b00) begin bad++; $display("FAIL single_done got busy=%b cv=%b rr=%b exp 0 0 00", ob, ocv, rr); end
    endtask

    task automatic test_contention;
        logic [1:0] exp_rr;
        rst = 1'b1; tick(); rst = 1'b0;
        cv = 2'b11; rd = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            total++; if (ob !== 1'b1 || og !== 1'((k % 2))) begin bad++; $display("FAIL cont_grant%0d got busy=%b grant=%h exp 1 %0d", k, ob, og, k % 2); end
            ir = 1'b1; ist = 2'b01; ird = 32'h100 + k;
            exp_rr = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++; if (rr !== exp_rr || status !== 2'b01 || rdata !== 32'h100 + k) begin bad++; $display("FAIL cont_resp%0d got rr=%b st=%b rd=%h exp %b 01 %h", k, rr, status, rdata, exp_rr, 32'h100 + k); end
            tick();
            ir = 1'b0;
            #1;
            total++; if (ob !== 1'b0 || rr !== 2'b00) begin bad++; $display("FAIL cont_gap%0d got busy=%b rr=%b exp 0 00", k, ob, rr); end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        rst = 1'b1; tick(); rst = 1'b0;
        cv = 2'b10; rd = 2'b10; ird = 32'hDEAD_BEEF; ist = 2'b01;
        tick(); #1;
        total++; if (ob !== 1'b1 || og !== 1'b1 || orrd !== 1'b1 || rr !== 2'b00) begin bad++; $display("FAIL tout_c1 got busy=%b grant=%h rd=%b rr=%b exp 1 1 1 00", ob, og, orrd, rr); end
        tick(); tick(); #1;
        total++; if (rr !== 2'b00 || ob !== 1'b1) begin bad++; $display("FAIL tout_c3 got rr=%b busy=%b exp 00 1", rr, ob); end
        tick(); #1;
        total++; if (rr !== 2'b10 || rdata !== 32'h0 || status !== 2'b11) begin bad++; $display("FAIL tout_c4 got rr=%b rd=%h st=%b exp 10 0 11", rr, rdata, status); end
        tick();
        clear_inputs();
        #1;
        total++; if (ob !== 1'b0 || rr !== 2'b00 || status !== 2'b00) begin bad++; $display("FAIL tout_idle got busy=%b rr=%b st=%b exp 0 00 00", ob, rr, status); end
    endtask

    task automatic test_tie;
        rst = 1'b1; tick(); rst = 1'b0;
        cv = 2'b01; rd = 2'b01;
        tick(); tick(); tick(); tick();
        ir = 1'b1; ird = 32'hCAFE_F00D; ist = 2'b00;
        #1;
        total++; if (rr !== 2'b01 || rdata !== 32'hCAFE_F00D || status !== 2'b00) begin bad++; $display("FAIL tie got rr=%b rd=%h st=%b exp 01 cafef00d 00", rr, rdata, status); end
        tick();
        clear_inputs();
        #1;
        total++; if (ob !== 1'b0) begin bad++; $display("FAIL tie_idle got busy=%b exp 0", ob); end
    endtask

    task automatic test_abort;
        rst = 1'b1; tick(); rst = 1'b0;
        cv = 2'b01; wr = 2'b01;
        tick();
        cv = 2'b11; wr = 2'b11;
        #1;
        total++; if (ob !== 1'b1 || og !== 1'b0) begin bad++; $display("FAIL abort_c1 got busy=%b grant=%h exp 1 0", ob, og); end
        tick();
        cv = 2'b10; ir = 1'b1;
        #1;
        total++; if (ocv !== 1'b0 || rr !== 2'b00) begin bad++; $display("FAIL abort_drop got cv=%b rr=%b exp 0 00", ocv, rr); end
        tick();
        ir = 1'b0;
        #1;
        total++; if (ob !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b exp 0", ob); end
        tick(); #1;
        total++; if (ob !== 1'b1 || og !== 1'b1 || ocv !== 1'b1) begin bad++; $display("FAIL abort_next got busy=%b grant=%h cv=%b exp 1 1 1", ob, og, ocv); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_busy;
        rst = 1'b1; tick(); rst = 1'b0;
        cv = 2'b10; rd = 2'b10; addr[15:8] = 8'h3C;
        tick(); #1;
        total++; if (ob !== 1'b1 || og !== 1'b1 || oa !== 8'h3C) begin bad++; $display("FAIL rmb_busy got busy=%b grant=%h a=%h exp 1 1 3c", ob, og, oa); end
        rst = 1'b1; ir = 1'b1; ird = 32'h1111_2222;
        tick();
        rst = 1'b0;
        #1;
        total++; if (ob !== 1'b0 || ocv !== 1'b0 || rr !== 2'b00 || og !== 1'b0 || oa !== 8'h00 || rdata !== 32'h0) begin bad++; $display("FAIL rmb_outs got busy=%b cv=%b rr=%b grant=%h a=%h rd=%h exp all 0", ob, ocv, rr, og, oa, rdata); end
        ir = 1'b0; cv = 2'b11; rd = 2'b11;
        tick(); #1;
        total++; if (ob !== 1'b1 || og !== 1'b0) begin bad++; $display("FAIL rmb_next got busy=%b grant=%h exp 1 0", ob, og); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_tie();
        test_abort();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
